// File: rtl/ne_dec_pkg.sv
// Shared definitions for the layered decoder scheduler.
//   state_t       : scheduler FSM encoding (IDLE / RUN / DRAIN)
//   ne_rowdepth() : row groups per layer, ceil(Z/P)
//   ne_plast()    : active RCUs in the final row group
//   ne_width()    : $clog2 with a floor of 1 bit
package ne_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic int ne_rowdepth(input int z, input int p);
      return (z + p - 1) / p;
   endfunction

   function automatic int ne_plast(input int z, input int p);
      return z - p * (ne_rowdepth(z, p) - 1);
   endfunction

   function automatic int ne_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ne_row_mask.sv
// P-lane enable mask for one row group.
//   i_rd   : row group is being read this cycle
//   i_last : current row group is the final (partial) one
//   o_mask : per-RCU enable; lanes at or above P_LAST drop out on the last row
module ne_row_mask #(
   parameter int P      = 26,
   parameter int P_LAST = 17
) (
   input  logic         i_rd,
   input  logic         i_last,
   output logic [P-1:0] o_mask
);

   genvar k;
   generate
      for (k = 0; k < P; k++) begin : g_lane
         if (k < P_LAST) begin : g_full
            assign o_mask[k] = i_rd;
         end else begin : g_tail
            assign o_mask[k] = i_rd & ~i_last;
         end
      end
   endgenerate

endmodule

// File: rtl/ne_layer_sched.sv
// Layer/iteration scheduler for a layered QC decoder.
// Walks ROWDEPTH row groups per layer (RUN), waits PIPESTAGES cycles for the
// RCU pipeline and write-back to empty (DRAIN), then moves to the next layer
// or iteration. Completes on syn_ok at the end of an iteration or when the
// latched iteration limit is reached.
//   clk, rst       : clock, synchronous active-low reset
//   loaden         : input buffer being reloaded, aborts any decode
//   start, max_itr : begin decode, iteration limit (0 treated as 1)
//   syn_ok         : parity satisfied, looked at on the last DRAIN cycle
//   SISOready      : result available (itr_done / early_term valid)
//   busy           : RUN or DRAIN
//   firstprocessing_indicate, LYRindex, rowaddress : position in the decode
//   rd_L, rd_E, rcu_en : memory read strobes and RCU enables
module ne_layer_sched
   import ne_dec_pkg::*;
#(
   parameter int  Z           = 511,
   parameter int  P           = 26,
   parameter int  LAYERS      = 2,
   parameter int  PIPESTAGES  = 13,
   parameter int  MAXITRS_CAP = 15,
   localparam int ROWDEPTH    = ne_rowdepth(Z, P),
   localparam int P_LAST      = ne_plast(Z, P),
   localparam int ROWW        = ne_width(ROWDEPTH),
   localparam int LYRW        = ne_width(LAYERS),
   localparam int PIPEW       = ne_width(PIPESTAGES),
   localparam int ITRW        = ne_width(MAXITRS_CAP + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            loaden,
   input  logic            start,
   input  logic [ITRW-1:0] max_itr,
   input  logic            syn_ok,
   output logic            SISOready,
   output logic            busy,
   output logic            firstprocessing_indicate,
   output logic [LYRW-1:0] LYRindex,
   output logic [ROWW-1:0] rowaddress,
   output logic            rd_L,
   output logic [P-1:0]    rd_E,
   output logic [P-1:0]    rcu_en,
   output logic [ITRW-1:0] itr_done,
   output logic            early_term
);

   state_t          r_state;
   logic [ROWW-1:0]  r_count;
   logic [PIPEW-1:0] r_pipecount;
   logic [LYRW-1:0]  r_lyr;
   logic [ITRW-1:0]  r_itr;
   logic [ITRW-1:0]  r_lim;
   logic             r_rd;
   logic             r_siso;
   logic             r_early;
   logic [ITRW-1:0]  r_itr_done;

   logic [ITRW-1:0]  w_lim;
   logic [ITRW-1:0]  w_itr_inc;
   logic             w_last_row;
   logic             w_last_pipe;
   logic             w_last_lyr;
   logic             w_rde_rd;

   // Limit of 0 still runs one iteration; clamp to the supported maximum.
   always_comb begin
      w_lim = (max_itr == '0) ? ITRW'(1) : max_itr;
      if (w_lim > ITRW'(MAXITRS_CAP))
         w_lim = ITRW'(MAXITRS_CAP);
   end

   // itr < lim <= MAXITRS_CAP, so the increment never wraps.
   assign w_itr_inc   = r_itr + ITRW'(1);
   assign w_last_row  = (r_count == ROWW'(ROWDEPTH - 1));
   assign w_last_pipe = (r_pipecount == PIPEW'(PIPESTAGES - 1));
   assign w_last_lyr  = (r_lyr == LYRW'(LAYERS - 1));
   // E-memory holds nothing useful until the first iteration has written it.
   assign w_rde_rd    = r_rd & (r_itr != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_pipecount <= '0;
         r_lyr       <= '0;
         r_itr       <= '0;
         r_lim       <= '0;
         r_rd        <= 1'b0;
         r_siso      <= 1'b0;
         r_early     <= 1'b0;
         r_itr_done  <= '0;
      end else if (loaden) begin
         // New codeword arriving: drop everything, start is ignored.
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_pipecount <= '0;
         r_lyr       <= '0;
         r_itr       <= '0;
         r_rd        <= 1'b0;
         r_siso      <= 1'b0;
         r_early     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state     <= ST_RUN;
                  r_count     <= '0;
                  r_pipecount <= '0;
                  r_lyr       <= '0;
                  r_itr       <= '0;
                  r_lim       <= w_lim;
                  r_rd        <= 1'b1;
                  r_siso      <= 1'b0;
                  r_early     <= 1'b0;
                  r_itr_done  <= '0;
               end
            end
            ST_RUN: begin
               if (w_last_row) begin
                  // Row address stays on the last group through DRAIN.
                  r_state     <= ST_DRAIN;
                  r_rd        <= 1'b0;
                  r_pipecount <= '0;
               end else begin
                  r_count <= r_count + ROWW'(1);
               end
            end
            ST_DRAIN: begin
               if (!w_last_pipe) begin
                  r_pipecount <= r_pipecount + PIPEW'(1);
               end else if (!w_last_lyr) begin
                  r_state <= ST_RUN;
                  r_lyr   <= r_lyr + LYRW'(1);
                  r_count <= '0;
                  r_rd    <= 1'b1;
               end else if (syn_ok) begin
                  r_state    <= ST_IDLE;
                  r_siso     <= 1'b1;
                  r_early    <= (w_itr_inc < r_lim);
                  r_itr_done <= w_itr_inc;
               end else if (w_itr_inc == r_lim) begin
                  r_state    <= ST_IDLE;
                  r_siso     <= 1'b1;
                  r_early    <= 1'b0;
                  r_itr_done <= r_lim;
               end else begin
                  r_state <= ST_RUN;
                  r_itr   <= w_itr_inc;
                  r_lyr   <= '0;
                  r_count <= '0;
                  r_rd    <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_rd    <= 1'b0;
            end
         endcase
      end
   end

   ne_row_mask #(.P(P), .P_LAST(P_LAST)) u_rcu_mask (
      .i_rd   (r_rd),
      .i_last (w_last_row),
      .o_mask (rcu_en)
   );

   ne_row_mask #(.P(P), .P_LAST(P_LAST)) u_rde_mask (
      .i_rd   (w_rde_rd),
      .i_last (w_last_row),
      .o_mask (rd_E)
   );

   assign SISOready                = r_siso;
   assign busy                     = (r_state != ST_IDLE);
   assign firstprocessing_indicate = (r_itr == '0) && (r_lyr == '0);
   assign LYRindex                 = r_lyr;
   assign rowaddress               = r_count;
   assign rd_L                     = r_rd;
   assign itr_done                 = r_itr_done;
   assign early_term               = r_early;

endmodule

// File: tb/tb_ne_layer_sched.sv
module tb_ne_layer_sched;

   localparam logic [31:0] M_ALL  = 32'h03FF_FFFF;
   localparam logic [31:0] M_TAIL = 32'h0001_FFFF;

   logic        clk, rst, loaden, start, start3, syn_ok, syn_ok3;
   logic [3:0]  max_itr;

   logic        SISOready, busy, first, rd_L, early_term;
   logic [0:0]  LYRindex;
   logic [4:0]  rowaddress;
   logic [25:0] rd_E, rcu_en;
   logic [3:0]  itr_done;

   logic        SISOready3, busy3, first3, rd_L3, early_term3;
   logic [1:0]  LYRindex3;
   logic [4:0]  rowaddress3;
   logic [25:0] rd_E3, rcu_en3;
   logic [3:0]  itr_done3;

   ne_layer_sched u_dut (
      .clk(clk), .rst(rst), .loaden(loaden), .start(start), .max_itr(max_itr),
      .syn_ok(syn_ok), .SISOready(SISOready), .busy(busy),
      .firstprocessing_indicate(first), .LYRindex(LYRindex),
      .rowaddress(rowaddress), .rd_L(rd_L), .rd_E(rd_E), .rcu_en(rcu_en),
      .itr_done(itr_done), .early_term(early_term)
   );

   ne_layer_sched #(.LAYERS(3)) u_dut3 (
      .clk(clk), .rst(rst), .loaden(loaden), .start(start3), .max_itr(max_itr),
      .syn_ok(syn_ok3), .SISOready(SISOready3), .busy(busy3),
      .firstprocessing_indicate(first3), .LYRindex(LYRindex3),
      .rowaddress(rowaddress3), .rd_L(rd_L3), .rd_E(rd_E3), .rcu_en(rcu_en3),
      .itr_done(itr_done3), .early_term(early_term3)
   );

   typedef struct {
      int itr;
      bit early;
      int cyc;
   } exp_t;

   exp_t q2[$];
   exp_t q3[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   t0;
   logic prev2  = 1'b0;
   logic prev3  = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input bit sel3, input int maxc);
      int i;
      i = 0;
      while (((sel3 ? busy3 : busy) == 1'b1) && (i < maxc)) begin
         step(1);
         i++;
      end
      if (i >= maxc) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", maxc);
      end
      step(2);
   endtask

   // Scoreboard monitors: pop on every rising SISOready.
   always @(negedge clk) begin
      if (rst && SISOready && !prev2) begin
         if (q2.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: completion at cycle %0d, none expected", cyc);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("done_itr", 32'(itr_done), 32'(e.itr));
            chk("done_early", 32'(early_term), 32'(e.early));
            chk("done_cycle", cyc, e.cyc);
         end
      end
      prev2 <= SISOready;
   end

   always @(negedge clk) begin
      if (rst && SISOready3 && !prev3) begin
         if (q3.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done3: completion at cycle %0d, none expected", cyc);
         end else begin
            exp_t e;
            e = q3.pop_front();
            chk("done3_itr", 32'(itr_done3), 32'(e.itr));
            chk("done3_early", 32'(early_term3), 32'(e.early));
            chk("done3_cycle", cyc, e.cyc);
         end
      end
      prev3 <= SISOready3;
   end

   task automatic go(input logic [3:0] mi);
      max_itr = mi;
      start   = 1'b1;
      step(1);
      start   = 1'b0;
      t0      = cyc;
   endtask

   initial begin
      rst = 1'b0; loaden = 1'b0; start = 1'b0; start3 = 1'b0;
      syn_ok = 1'b0; syn_ok3 = 1'b0; max_itr = 4'd0;
      step(3);
      chk("rst_siso", 32'(SISOready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdL", 32'(rd_L), 0);
      chk("rst_rcu", 32'(rcu_en), 0);
      chk("rst_itrdone", 32'(itr_done), 0);
      chk("rst_early", 32'(early_term), 0);
      rst = 1'b1;
      step(1);

      // Three iterations, no syndrome pass; mask and rd_E pattern along the way.
      go(4'd3);
      q2.push_back('{itr: 3, early: 1'b0, cyc: t0 + 198});
      chk("a_busy", 32'(busy), 1);
      chk("a_first", 32'(first), 1);
      chk("a_row0", 32'(rowaddress), 0);
      chk("a_rcu_row0", 32'(rcu_en), M_ALL);
      chk("a_rde_itr0", 32'(rd_E), 0);
      step(19);
      chk("a_row19", 32'(rowaddress), 19);
      chk("a_rcu_row19", 32'(rcu_en), M_TAIL);
      chk("a_rde_row19", 32'(rd_E), 0);
      step(1);
      chk("a_drain_rdL", 32'(rd_L), 0);
      chk("a_drain_rcu", 32'(rcu_en), 0);
      start = 1'b1;                      // ignored while busy
      step(1);
      start = 1'b0;
      step(12);                          // T+33: layer 1 begins
      chk("a_lyr1", 32'(LYRindex), 1);
      chk("a_lyr1_row", 32'(rowaddress), 0);
      chk("a_lyr1_first", 32'(first), 0);
      step(33);                          // T+66: iteration 1, layer 0
      chk("a_itr1_rde", 32'(rd_E), M_ALL);
      chk("a_itr1_lyr", 32'(LYRindex), 0);
      step(19);
      chk("a_itr1_rde19", 32'(rd_E), M_TAIL);
      chk("a_itr1_rcu19", 32'(rcu_en), M_TAIL);
      wait_idle(1'b0, 300);
      step(5);
      chk("a_hold_siso", 32'(SISOready), 1);
      chk("a_hold_itr", 32'(itr_done), 3);

      // Limit of zero still runs one iteration.
      go(4'd0);
      q2.push_back('{itr: 1, early: 1'b0, cyc: t0 + 66});
      chk("b_siso_clr", 32'(SISOready), 0);
      wait_idle(1'b0, 200);

      // Syndrome satisfied at end of iteration 1 with limit 5.
      go(4'd5);
      q2.push_back('{itr: 2, early: 1'b1, cyc: t0 + 132});
      step(70);
      syn_ok = 1'b1;
      wait_idle(1'b0, 200);
      syn_ok = 1'b0;

      // Syndrome satisfied exactly on the limit: not an early termination.
      syn_ok = 1'b1;
      go(4'd1);
      q2.push_back('{itr: 1, early: 1'b0, cyc: t0 + 66});
      wait_idle(1'b0, 200);
      syn_ok = 1'b0;

      // loaden clears a held result, aborts a decode, and beats start.
      loaden = 1'b1;
      step(1);
      loaden = 1'b0;
      chk("l_idle_siso", 32'(SISOready), 0);
      go(4'd3);
      step(38);
      chk("l_mid_lyr", 32'(LYRindex), 1);
      loaden = 1'b1;
      step(1);
      loaden = 1'b0;
      chk("l_busy", 32'(busy), 0);
      chk("l_rdL", 32'(rd_L), 0);
      chk("l_siso", 32'(SISOready), 0);
      chk("l_lyr", 32'(LYRindex), 0);
      chk("l_first", 32'(first), 1);
      loaden = 1'b1;
      start  = 1'b1;
      step(1);
      loaden = 1'b0;
      start  = 1'b0;
      chk("l_start_drop", 32'(busy), 0);
      go(4'd1);
      q2.push_back('{itr: 1, early: 1'b0, cyc: t0 + 66});
      chk("l_restart_first", 32'(first), 1);
      chk("l_restart_rdL", 32'(rd_L), 1);
      chk("l_restart_row", 32'(rowaddress), 0);
      wait_idle(1'b0, 200);

      // Reset in the middle of DRAIN.
      go(4'd3);
      step(25);
      chk("r_drain_rdL", 32'(rd_L), 0);
      rst = 1'b0;
      step(1);
      chk("r_busy", 32'(busy), 0);
      chk("r_rdL", 32'(rd_L), 0);
      chk("r_siso", 32'(SISOready), 0);
      chk("r_itrdone", 32'(itr_done), 0);
      chk("r_rcu", 32'(rcu_en), 0);
      chk("r_row", 32'(rowaddress), 0);
      rst = 1'b1;
      step(2);

      // Three-layer instance: early termination at end of iteration 1.
      max_itr = 4'd5;
      start3  = 1'b1;
      step(1);
      start3  = 1'b0;
      t0      = cyc;
      q3.push_back('{itr: 2, early: 1'b1, cyc: t0 + 198});
      step(105);
      syn_ok3 = 1'b1;
      wait_idle(1'b1, 200);
      syn_ok3 = 1'b0;

      chk("q2_empty", q2.size(), 0);
      chk("q3_empty", q3.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
